cart_mbc1: RTL and testbench
============================

// Module: cart_mbc1
// PURPOSE
//  Cartridge-side responder for the Game Boy external bus: an MBC1 mapper that
//  decodes bus writes into bank registers and maps CPU addresses to physical ROM/RAM.
//  Sits at the far end of the top-level cartridge interface (a/dout/din/wr/rd).
//  Drives an external ROM port and holds cartridge RAM in an internal single-port RAM.
// PARAMETERS
//  ROM_AW     21  physical ROM address width in bits; ROM size = 2**ROM_AW bytes, 16 KiB banks
//  RAM_BANKS  4   8 KiB cart RAM banks: 0, 1 or 4; 0 = no RAM
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset: synchronous, active-high
//  a          in   16       bus address
//  din        in   8        bus write data (from console dout)
//  dout       out  8        bus read data (to console din)
//  wr         in   1        bus write enable, level; may stay high for several clocks
//  rd         in   1        bus read enable
//  rom_a      out  ROM_AW   physical ROM byte address
//  rom_rd     out  1        ROM read strobe = rd & (a < 16'h8000)
//  rom_d      in   8        ROM data, combinational from rom_a
//  d_rom_bank out  7        effective 0x4000-0x7FFF bank number, for debug
// BEHAVIOUR
//  Registers: ram_en (1b), bank1 (5b), bank2 (2b), mode (1b), wr_q (1b).
//  Reset values: ram_en=0, bank1=5'h01, bank2=0, mode=0, wr_q=1.
//  wr_q=1 at reset: a wr held high across reset release does not commit.
//  Commit point: a register or RAM write happens only on the cycle with wr & ~wr_q.
//  Exactly one commit per wr assertion. wr_q <= wr every cycle.
//  Writes, committed on the wr rising edge:
//   0000-1FFF: ram_en <= (din[3:0]==4'hA).
//   2000-3FFF: bank1 <= (din[4:0]==0) ? 5'h01 : din[4:0].
//   4000-5FFF: bank2 <= din[1:0].
//   6000-7FFF: mode <= din[0].
//   A000-BFFF: RAM write only when ram_en and RAM_BANKS>0. Otherwise the write is dropped.
//   All other addresses are ignored.
//  ROM mapping, purely combinational:
//   0000-3FFF: rom_a = {mode ? bank2 : 2'b0, 5'b0, a[13:0]}.
//   4000-7FFF: rom_a = {bank2, bank1, a[13:0]}.
//   Concatenations are truncated to the low ROM_AW bits. Bank numbers wrap modulo ROM size.
//   d_rom_bank = {bank2, bank1}.
//  RAM mapping:
//   ram index = {mode ? bank2 : 2'b0, a[12:0]}, masked to log2(RAM_BANKS*8192) bits.
//   RAM_BANKS=1 ignores bank2.
//  Read data (dout):
//   a<8000: rom_d, combinational, zero latency.
//   A000-BFFF with ram_en and RAM present: RAM data, valid 1 clk after a is stable.
//   A000-BFFF with RAM disabled or absent: 8'hFF.
//   Any other address: 8'hFF.
//  dout does not depend on rd. rd only gates rom_rd. RAM data is unknown until the first read after reset.
//  Simultaneous events: wr and rd both high means the write commits; dout still follows the read mux.
//  Reset mid-operation: banks return to reset values next clk. RAM contents are preserved.
// CONFIGURATION
//  MBC1_MULTICART_EN defined (MBC1M wiring):
//   4000-7FFF maps to {bank2, bank1[3:0], a[13:0]}.
//   0000-3FFF in mode 1 maps to {bank2, 4'b0, a[13:0]}.
//   The zero-to-one substitution still tests all 5 bits of din.
//   d_rom_bank = {1'b0, bank2, bank1[3:0]}.
//  MBC1_MULTICART_EN undefined: standard MBC1 mapping as above.
// TESTING
//  1. Reset, then read 0x0150 and 0x4000.
//     -> rom_a = 0x00150 and 0x04000; d_rom_bank = 1.
//  2. Write 0x00 to 0x2000, then read 0x4123.
//     -> bank1 = 1; rom_a = 0x04123.
//     Write 0x13 to 0x2000 and 0x02 to 0x4000.
//     -> d_rom_bank = 0x53; rom_a for 0x4123 = 0x14C123 (0x53*0x4000 + 0x0123).
//  3. Hold wr high 4 clks at 0x2000 with din 0x05, then change din to 0x07 while wr stays high.
//     -> bank1 = 5; no second commit.
//  4. Write 0xFF to 0xA000 while ram_en=0.
//     -> reads give 0xFF.
//     Write 0x0A to 0x0000, 0x01 to 0x6000, 0x03 to 0x4000, then 0x5A to 0xA010; read 0xA010.
//     -> 0x5A one clk later.
//     Switch to mode 0 and read 0xA010.
//     -> bank 0 data, not 0x5A.
//  5. Assert rst for 1 clk mid-sequence, with wr held high across release.
//     -> ram_en = 0, bank1 = 1, bank2 = 0, mode = 0; no commit until wr falls and rises again.
//  6. With MBC1_MULTICART_EN: write 0x13 to 0x2000 and 0x01 to 0x4000.
//     -> d_rom_bank = 0x13 (bank2 = 1, bank1[3:0] = 3).

Source files
------------

// File: rtl/cart_mbc1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cart_mbc1 : MBC1 cartridge mapper. Decodes bus writes into bank          |
// |             registers, maps CPU addresses onto ROM and internal cart RAM.|
// | Optional  : MBC1_MULTICART_EN selects MBC1M (multicart) bank wiring.     |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module cart_mbc1 #(
  parameter int ROM_AW    = 21,
  parameter int RAM_BANKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       a,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  input  logic              wr,
  input  logic              rd,
  output logic [ROM_AW-1:0] rom_a,
  output logic              rom_rd,
  input  logic [7:0]        rom_d,
  output logic [6:0]        d_rom_bank
);

  logic       ram_en_q, ram_en_d;
  logic [4:0] bank1_q,  bank1_d;
  logic [1:0] bank2_q,  bank2_d;
  logic       mode_q,   mode_d;
  logic       wr_q;

  logic        w_commit;
  logic        w_ram_we;
  logic        w_ram_area;
  logic [1:0]  w_hi_sel;
  logic [6:0]  w_lo_bank;
  logic [6:0]  w_hi_bank;
  logic [20:0] w_rom_full;
  logic [14:0] w_ram_idx;
  logic [7:0]  w_ram_rdata;

  // Only the rising edge of wr commits; wr_q powers up high so a level held through reset is ignored.
  assign w_commit   = wr & ~wr_q & ~rst;
  assign w_ram_area = (a[15:13] == 3'b101);
  assign w_ram_we   = w_commit & w_ram_area & ram_en_q & (RAM_BANKS > 0);

  always_comb begin
    ram_en_d = ram_en_q;
    bank1_d  = bank1_q;
    bank2_d  = bank2_q;
    mode_d   = mode_q;
    if (w_commit) begin
      case (a[15:13])
        3'b000:  ram_en_d = (din[3:0] == 4'hA);
        3'b001:  bank1_d  = (din[4:0] == 5'd0) ? 5'd1 : din[4:0];
        3'b010:  bank2_d  = din[1:0];
        3'b011:  mode_d   = din[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en_q <= 1'b0;
      bank1_q  <= 5'd1;
      bank2_q  <= 2'd0;
      mode_q   <= 1'b0;
      wr_q     <= 1'b1;
    end else begin
      ram_en_q <= ram_en_d;
      bank1_q  <= bank1_d;
      bank2_q  <= bank2_d;
      mode_q   <= mode_d;
      wr_q     <= wr;
    end
  end

  assign w_hi_sel = mode_q ? bank2_q : 2'b00;

`ifdef MBC1_MULTICART_EN
  // MBC1M: bank1 bit 4 is not wired, bank2 lands one bit lower.
  assign w_lo_bank = {1'b0, w_hi_sel, 4'b0000};
  assign w_hi_bank = {1'b0, bank2_q, bank1_q[3:0]};
`else
  assign w_lo_bank = {w_hi_sel, 5'b00000};
  assign w_hi_bank = {bank2_q, bank1_q};
`endif

  assign d_rom_bank = w_hi_bank;
  assign w_rom_full = {(a[14] ? w_hi_bank : w_lo_bank), a[13:0]};
  assign rom_rd     = rd & ~a[15];

  generate
    if (ROM_AW <= 21) begin : g_rom_trunc
      assign rom_a = w_rom_full[ROM_AW-1:0];
    end else begin : g_rom_ext
      assign rom_a = {{(ROM_AW-21){1'b0}}, w_rom_full};
    end
  endgenerate

  assign w_ram_idx = {w_hi_sel, a[12:0]};

  generate
    if (RAM_BANKS > 0) begin : g_ram
      localparam int RAM_AW = (RAM_BANKS > 1) ? 15 : 13;
      logic [7:0] mem_q [0:(1<<RAM_AW)-1];
      logic [7:0] rdata_q;
      // Contents survive reset; read data is registered (one clock latency).
      always_ff @(posedge clk) begin
        if (w_ram_we) mem_q[w_ram_idx[RAM_AW-1:0]] <= din;
        rdata_q <= mem_q[w_ram_idx[RAM_AW-1:0]];
      end
      assign w_ram_rdata = rdata_q;
    end else begin : g_no_ram
      assign w_ram_rdata = 8'hFF;
    end
  endgenerate

  always_comb begin
    dout = 8'hFF;
    if (!a[15]) begin
      dout = rom_d;
    end else if (w_ram_area && ram_en_q && (RAM_BANKS > 0)) begin
      dout = w_ram_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cart_mbc1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cart_mbc1 : directed + randomized bench for cart_mbc1 against a       |
// |                bank-arithmetic reference model. Revision : 1.0          |
// +--------------------------------------------------------------------------+
module tb_cart_mbc1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        wr;
  logic        rd;
  logic [20:0] rom_a;
  logic        rom_rd;
  logic [7:0]  rom_d;
  logic [6:0]  d_rom_bank;

  int vectors = 0;
  int fails   = 0;

  // Reference model state
  int  m_ram_en, m_bank1, m_bank2, m_mode;
  byte m_ram [int];

  cart_mbc1 #(.ROM_AW(21), .RAM_BANKS(4)) dut (
    .clk(clk), .rst(rst), .a(a), .din(din), .dout(dout), .wr(wr), .rd(rd),
    .rom_a(rom_a), .rom_rd(rom_rd), .rom_d(rom_d), .d_rom_bank(d_rom_bank)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] romf(input logic [20:0] x);
    return x[7:0] ^ x[15:8] ^ {x[20:16], 3'b101};
  endfunction

  assign rom_d = romf(rom_a);

  function automatic int exp_bank();
`ifdef MBC1_MULTICART_EN
    return m_bank2 * 16 + (m_bank1 % 16);
`else
    return m_bank2 * 32 + m_bank1;
`endif
  endfunction

  function automatic logic [20:0] exp_rom_a(input int addr);
    int bank;
    int v;
    if (addr < 16'h4000) begin
`ifdef MBC1_MULTICART_EN
      bank = m_mode ? m_bank2 * 16 : 0;
`else
      bank = m_mode ? m_bank2 * 32 : 0;
`endif
    end else begin
      bank = exp_bank();
    end
    v = (bank * 16384 + (addr % 16384)) % (1 << 21);
    return v[20:0];
  endfunction

  function automatic int ram_index(input int addr);
    return (m_mode ? m_bank2 : 0) * 8192 + (addr - 16'hA000);
  endfunction

  task automatic model_reset();
    m_ram_en = 0; m_bank1 = 1; m_bank2 = 0; m_mode = 0;
  endtask

  task automatic model_write(input int addr, input int data);
    if (addr < 16'h2000)       m_ram_en = ((data % 16) == 10) ? 1 : 0;
    else if (addr < 16'h4000)  m_bank1 = ((data % 32) == 0) ? 1 : (data % 32);
    else if (addr < 16'h6000)  m_bank2 = data % 4;
    else if (addr < 16'h8000)  m_mode = data % 2;
    else if (addr >= 16'hA000 && addr < 16'hC000 && m_ram_en != 0)
      m_ram[ram_index(addr)] = byte'(data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    a   = addr;
    din = data;
    rd  = 1'($urandom % 2);
    wr  = 1'b1;
    tick();
    wr  = 1'b0;
    rd  = 1'b0;
    model_write(int'(addr), int'(data));
    tick();
  endtask

  // Read one address and check every output the model predicts.
  task automatic rd_chk(input logic [15:0] addr);
    int ai;
    ai = int'(addr);
    a  = addr;
    rd = 1'b1;
    #1;
    chk("rom_rd", 32'(rom_rd), 32'(ai < 16'h8000));
    chk("d_rom_bank", 32'(d_rom_bank), 32'(exp_bank()));
    if (ai < 16'h8000) begin
      chk("rom_a", 32'(rom_a), 32'(exp_rom_a(ai)));
      chk("dout_rom", 32'(dout), 32'(romf(exp_rom_a(ai))));
    end else if (ai >= 16'hA000 && ai < 16'hC000 && m_ram_en != 0) begin
      tick();
      if (m_ram.exists(ram_index(ai)))
        chk("dout_ram", 32'(dout), 32'(8'(m_ram[ram_index(ai)])));
    end else begin
      chk("dout_ff", 32'(dout), 32'h0000_00FF);
    end
    rd = 1'b0;
  endtask

  initial begin
    int op;
    logic [15:0] ra;
    logic [7:0]  rdat;

    rst = 1'b1; wr = 1'b0; rd = 1'b0; a = 16'h0000; din = 8'h00;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state and boot reads
    chk("reset_bank", 32'(d_rom_bank), 32'h1);
    a = 16'h0150; #1;
    chk("rom_a_0150", 32'(rom_a), 32'h00150);
    a = 16'h4000; #1;
    chk("rom_a_4000", 32'(rom_a), 32'h04000);
    rd_chk(16'h0150);

    // Bank 0 request becomes bank 1; high bank arithmetic
    bus_write(16'h2000, 8'h00);
    a = 16'h4123; #1;
    chk("bank0_to_1", 32'(rom_a), 32'h04123);
    bus_write(16'h2000, 8'h13);
    bus_write(16'h4000, 8'h02);
    a = 16'h4123; #1;
`ifdef MBC1_MULTICART_EN
    chk("bank_53_mc", 32'(d_rom_bank), 32'h23);
`else
    chk("bank_53", 32'(d_rom_bank), 32'h53);
    chk("rom_a_14C123", 32'(rom_a), 32'h14C123);
`endif
    rd_chk(16'h4123);
    rd_chk(16'h0000);

    // wr held high: single commit
    a = 16'h2000; din = 8'h05; wr = 1'b1;
    repeat (4) tick();
    din = 8'h07;
    repeat (2) tick();
    model_write(16'h2000, 8'h05);
    chk("held_wr_bank", 32'(d_rom_bank), 32'(exp_bank()));
    chk("held_wr_b1", 32'(d_rom_bank[3:0]), 32'h5);
    wr = 1'b0;
    tick();

    // RAM enable gating, banking and mode
    bus_write(16'hA000, 8'hFF);
    rd_chk(16'hA000);
    bus_write(16'h6000, 8'h00);
    bus_write(16'h0000, 8'h0A);
    bus_write(16'hA010, 8'h11);
    bus_write(16'h6000, 8'h01);
    bus_write(16'h4000, 8'h03);
    bus_write(16'hA010, 8'h5A);
    a = 16'hA010; tick();
    chk("ram_bank3", 32'(dout), 32'h5A);
    bus_write(16'h6000, 8'h00);
    a = 16'hA010; tick();
    chk("ram_bank0", 32'(dout), 32'h11);
    rd_chk(16'hC000);
    rd_chk(16'h9000);

    // Reset mid-sequence with wr held high across release
    a = 16'h2000; din = 8'h09; wr = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    repeat (2) tick();
    chk("rst_bank", 32'(d_rom_bank), 32'h1);
    rd_chk(16'hA010);
    rd_chk(16'h0150);
    wr = 1'b0; tick();
    a = 16'h2000; wr = 1'b1; tick();
    wr = 1'b0;
    model_write(16'h2000, 8'h09);
    tick();
    chk("rst_recommit", 32'(d_rom_bank), 32'(exp_bank()));

    // Multicart bank wiring example
    bus_write(16'h2000, 8'h13);
    bus_write(16'h4000, 8'h01);
`ifdef MBC1_MULTICART_EN
    chk("mc_bank", 32'(d_rom_bank), 32'h13);
`else
    chk("std_bank", 32'(d_rom_bank), 32'h33);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      op   = int'($urandom % 6);
      rdat = 8'($urandom);
      case (op)
        0: begin
          ra = 16'($urandom % 16'h2000);
          bus_write(ra, ($urandom % 2) ? 8'h0A : rdat);
        end
        1: bus_write(16'($urandom % 16'h6000) & 16'h7FFF | 16'h2000, rdat);
        2: bus_write(16'h6000 + 16'($urandom % 16'h2000), rdat);
        3: bus_write(16'hA000 + 16'($urandom % 16'h2000), rdat);
        4: rd_chk(16'hA000 + 16'($urandom % 16'h2000));
        default: rd_chk(16'($urandom));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
